// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit CPU front end: opcodes, instruction field
// positions and the fetch FSM state encoding.
package cpu16_pkg;

  // Opcode values in IR[15:13]
  localparam logic [2:0] OP_R    = 3'b111;
  localparam logic [2:0] OP_ADDI = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_SW   = 3'b110;
  localparam logic [2:0] OP_SLTI = 3'b100;

  // Instruction field bit positions
  localparam int unsigned OPCODE_HI = 15;
  localparam int unsigned OPCODE_LO = 13;
  localparam int unsigned RS_HI     = 12;
  localparam int unsigned RS_LO     = 11;
  localparam int unsigned RT_HI     = 10;
  localparam int unsigned RT_LO     = 9;
  localparam int unsigned RD_HI     = 8;
  localparam int unsigned RD_LO     = 7;
  localparam int unsigned FUNCT_HI  = 2;
  localparam int unsigned FUNCT_LO  = 0;
  localparam int unsigned IMM_HI    = 8;
  localparam int unsigned IMM_LO    = 0;

  // Fetch FSM states
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StFetch = 2'b01,
    StIssue = 2'b10
  } fetch_state_e;

  // Sign-extend a 9-bit immediate to 16 bits
  function automatic logic [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

endpackage

// File: rtl/instr_decode_fields.sv
// Splits an instruction word into its register, function and immediate fields.
// Purely combinational; outputs follow the instruction register directly.
module instr_decode_fields
  import cpu16_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  rs,
  output logic [1:0]  rt,
  output logic [1:0]  rd,
  output logic [2:0]  funct,
  output logic [15:0] imm
);

  assign opcode = ir[OPCODE_HI:OPCODE_LO];
  assign rs     = ir[RS_HI:RS_LO];
  assign rt     = ir[RT_HI:RT_LO];
  assign rd     = ir[RD_HI:RD_LO];
  assign funct  = ir[FUNCT_HI:FUNCT_LO];
  assign imm    = sext9(ir[IMM_HI:IMM_LO]);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: keeps the PC, issues one memory request at a time,
// holds the fetched word in IR until downstream consumes it, and handles
// branch redirects including responses that arrive after a redirect.
module instruction_fetch
  import cpu16_pkg::*;
#(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int unsigned IMEM_LAT_MAX = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic        IMemReq,
  output logic [15:0] IMemAddr,
  input  logic        IMemValid,
  input  logic [15:0] IMemData,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [15:0] BranchTarget,
  output logic        InstrValid,
  output logic [2:0]  OPCODE,
  output logic [1:0]  Rs,
  output logic [1:0]  Rt,
  output logic [1:0]  Rd,
  output logic [2:0]  Funct,
  output logic [15:0] Imm,
  output logic [15:0] PCOut
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  addr_q, addr_d;  // address of the outstanding request
  logic [15:0]  ir_q, ir_d;
  logic         flush_q, flush_d;  // outstanding response belongs to a stale PC
  logic         valid_q, valid_d;
  logic [15:0]  branch_pc;
  int unsigned  lat_cnt;

  assign branch_pc = BranchTarget & 16'hFFFE;

  // State register with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      ir_q    <= 16'h0000;
      flush_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      flush_q <= flush_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic: branch outranks consume and stall in every state
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    flush_d = flush_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        addr_d  = pc_q;
      end
      StFetch: begin
        if (IMemValid) begin
          flush_d = 1'b0;
          if (BranchTaken) begin
            // Response raced a redirect: drop it, refetch from the target
            pc_d   = branch_pc;
            addr_d = branch_pc;
          end else if (flush_q) begin
            // Stale response: drop it, request the redirected PC next cycle
            addr_d = pc_q;
          end else begin
            ir_d    = IMemData;
            valid_d = 1'b1;
            state_d = StIssue;
          end
        end else if (BranchTaken) begin
          // Keep the address stable for the in-flight request; discard later
          pc_d    = branch_pc;
          flush_d = 1'b1;
        end
      end
      StIssue: begin
        if (BranchTaken) begin
          pc_d    = branch_pc;
          addr_d  = branch_pc;
          valid_d = 1'b0;
          state_d = StFetch;
        end else if (!Stall) begin
          pc_d    = pc_q + 16'd2;
          addr_d  = pc_q + 16'd2;
          valid_d = 1'b0;
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign IMemReq    = (state_q == StFetch);
  assign IMemAddr   = addr_q;
  assign InstrValid = valid_q;
  assign PCOut      = pc_q;

  instr_decode_fields u_decode (
    .ir     (ir_q),
    .opcode (OPCODE),
    .rs     (Rs),
    .rt     (Rt),
    .rd     (Rd),
    .funct  (Funct),
    .imm    (Imm)
  );

  // Count cycles a request has waited without a response
  always_ff @(posedge Clock) begin
    if (Reset || !IMemReq || IMemValid) begin
      lat_cnt <= 0;
    end else begin
      lat_cnt <= lat_cnt + 1;
    end
  end

  // Memory must answer within IMEM_LAT_MAX cycles
  a_imem_latency: assert property (@(posedge Clock) disable iff (Reset)
    lat_cnt <= IMEM_LAT_MAX);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by a
// randomized run checked against a transaction-level reference model.
module tb_instruction_fetch;

  logic        Clock;
  logic        Reset;
  logic        IMemReq;
  logic [15:0] IMemAddr;
  logic        IMemValid;
  logic [15:0] IMemData;
  logic        Stall;
  logic        BranchTaken;
  logic [15:0] BranchTarget;
  logic        InstrValid;
  logic [2:0]  OPCODE;
  logic [1:0]  Rs, Rt, Rd;
  logic [2:0]  Funct;
  logic [15:0] Imm;
  logic [15:0] PCOut;

  // Second instance exercising a reset PC at the top of the address space
  logic        w_Reset;
  logic        w_IMemReq;
  logic [15:0] w_IMemAddr;
  logic        w_IMemValid;
  logic [15:0] w_IMemData;
  logic        w_Stall;
  logic        w_BranchTaken;
  logic [15:0] w_BranchTarget;
  logic        w_InstrValid;
  logic [2:0]  w_OPCODE;
  logic [1:0]  w_Rs, w_Rt, w_Rd;
  logic [2:0]  w_Funct;
  logic [15:0] w_Imm;
  logic [15:0] w_PCOut;

  int checks;
  int failures;

  instruction_fetch #(.RESET_PC(16'h0000), .IMEM_LAT_MAX(8)) dut (
    .Clock(Clock), .Reset(Reset), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemValid(IMemValid), .IMemData(IMemData), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .InstrValid(InstrValid),
    .OPCODE(OPCODE), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Funct(Funct), .Imm(Imm), .PCOut(PCOut)
  );

  instruction_fetch #(.RESET_PC(16'hFFFE), .IMEM_LAT_MAX(8)) dut_wrap (
    .Clock(Clock), .Reset(w_Reset), .IMemReq(w_IMemReq), .IMemAddr(w_IMemAddr),
    .IMemValid(w_IMemValid), .IMemData(w_IMemData), .Stall(w_Stall),
    .BranchTaken(w_BranchTaken), .BranchTarget(w_BranchTarget),
    .InstrValid(w_InstrValid), .OPCODE(w_OPCODE), .Rs(w_Rs), .Rt(w_Rt), .Rd(w_Rd),
    .Funct(w_Funct), .Imm(w_Imm), .PCOut(w_PCOut)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance one cycle and settle past the active edge
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Memory contents: a fixed scramble of the address
  function automatic logic [15:0] memword(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h6B1D;
  endfunction

  // Expected {opcode, rs, rt, rd, funct, imm} of a word
  function automatic logic [27:0] exp_fields(input logic [15:0] w);
    logic [2:0]  op, fn;
    logic [1:0]  rs, rt, rd;
    logic [15:0] imm;
    op  = 3'((w >> 13) & 16'h7);
    rs  = 2'((w >> 11) & 16'h3);
    rt  = 2'((w >> 9) & 16'h3);
    rd  = 2'((w >> 7) & 16'h3);
    fn  = 3'(w & 16'h7);
    imm = w & 16'h01FF;
    if ((w & 16'h0100) != 16'h0000) imm = imm | 16'hFE00;
    return {op, rs, rt, rd, fn, imm};
  endfunction

  task automatic clear_inputs();
    IMemValid    = 1'b0;
    IMemData     = 16'h0000;
    Stall        = 1'b0;
    BranchTaken  = 1'b0;
    BranchTarget = 16'h0000;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    clear_inputs();
    step();
    step();
    Reset = 1'b0;
    checks++;
    if (IMemReq !== 1'b0 || InstrValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: req=%b valid=%b, required req=0 valid=0", IMemReq, InstrValid);
    end
    checks++;
    if ({OPCODE, Rs, Rt, Rd, Funct, Imm} !== 28'h0) begin
      failures++;
      $display("FAIL reset_decode: got %h, required 0", {OPCODE, Rs, Rt, Rd, Funct, Imm});
    end
    checks++;
    if (PCOut !== 16'h0000) begin
      failures++;
      $display("FAIL reset_pc: got %h, required 0000", PCOut);
    end
    step();
    checks++;
    if (IMemReq !== 1'b1 || IMemAddr !== 16'h0000) begin
      failures++;
      $display("FAIL first_req: req=%b addr=%h, required req=1 addr=0000", IMemReq, IMemAddr);
    end
  endtask

  task automatic test_basic_issue();
    IMemValid = 1'b1;
    IMemData  = 16'hE283;
    step();
    IMemValid = 1'b0;
    IMemData  = 16'h0000;
    checks++;
    if (InstrValid !== 1'b1 || IMemReq !== 1'b0) begin
      failures++;
      $display("FAIL basic_valid: valid=%b req=%b, required valid=1 req=0", InstrValid, IMemReq);
    end
    checks++;
    if (OPCODE !== 3'b111 || Rs !== 2'd0 || Rt !== 2'd1 || Rd !== 2'd1 || Funct !== 3'd3) begin
      failures++;
      $display("FAIL basic_fields: op=%b rs=%0d rt=%0d rd=%0d funct=%0d, required 111 0 1 1 3",
               OPCODE, Rs, Rt, Rd, Funct);
    end
    checks++;
    if (PCOut !== 16'h0000) begin
      failures++;
      $display("FAIL basic_pcout: got %h, required 0000", PCOut);
    end
    step();
    checks++;
    if (IMemReq !== 1'b1 || IMemAddr !== 16'h0002 || InstrValid !== 1'b0) begin
      failures++;
      $display("FAIL basic_next_fetch: req=%b addr=%h valid=%b, required 1 0002 0",
               IMemReq, IMemAddr, InstrValid);
    end
  endtask

  task automatic test_stall_hold();
    int reqs;
    reqs      = 0;
    IMemValid = 1'b1;
    IMemData  = 16'h61FF;
    Stall     = 1'b1;
    step();
    IMemValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (InstrValid !== 1'b1 || Imm !== 16'hFFFF || PCOut !== 16'h0002) begin
        failures++;
        $display("FAIL stall_hold[%0d]: valid=%b imm=%h pc=%h, required 1 FFFF 0002",
                 i, InstrValid, Imm, PCOut);
      end
      if (IMemReq === 1'b1) reqs++;
      step();
    end
    checks++;
    if (InstrValid !== 1'b1) begin
      failures++;
      $display("FAIL stall_last: valid=%b, required 1", InstrValid);
    end
    Stall = 1'b0;
    step();
    checks++;
    if (reqs != 0) begin
      failures++;
      $display("FAIL stall_no_req: requests during stall=%0d, required 0", reqs);
    end
    checks++;
    if (IMemReq !== 1'b1 || IMemAddr !== 16'h0004) begin
      failures++;
      $display("FAIL stall_next_fetch: req=%b addr=%h, required 1 0004", IMemReq, IMemAddr);
    end
  endtask

  task automatic test_flush();
    step();
    BranchTaken  = 1'b1;
    BranchTarget = 16'h0041;
    step();
    BranchTaken  = 1'b0;
    checks++;
    if (IMemReq !== 1'b1 || IMemAddr !== 16'h0004) begin
      failures++;
      $display("FAIL flush_addr_stable: req=%b addr=%h, required 1 0004", IMemReq, IMemAddr);
    end
    step();
    IMemValid = 1'b1;
    IMemData  = 16'hE283;
    step();
    IMemValid = 1'b0;
    checks++;
    if (InstrValid !== 1'b0) begin
      failures++;
      $display("FAIL flush_dropped: valid=%b, required 0", InstrValid);
    end
    checks++;
    if (IMemReq !== 1'b1 || IMemAddr !== 16'h0040) begin
      failures++;
      $display("FAIL flush_refetch: req=%b addr=%h, required 1 0040", IMemReq, IMemAddr);
    end
    IMemValid = 1'b1;
    IMemData  = 16'h7ABC;
    step();
    IMemValid = 1'b0;
    checks++;
    if (InstrValid !== 1'b1 || PCOut !== 16'h0040 ||
        {OPCODE, Rs, Rt, Rd, Funct, Imm} !== exp_fields(16'h7ABC)) begin
      failures++;
      $display("FAIL flush_issue: valid=%b pc=%h fields=%h, required 1 0040 %h",
               InstrValid, PCOut, {OPCODE, Rs, Rt, Rd, Funct, Imm}, exp_fields(16'h7ABC));
    end
  endtask

  task automatic test_branch_stall();
    Stall        = 1'b1;
    BranchTaken  = 1'b1;
    BranchTarget = 16'h0100;
    step();
    Stall        = 1'b0;
    BranchTaken  = 1'b0;
    checks++;
    if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 16'h0100) begin
      failures++;
      $display("FAIL branch_stall: valid=%b req=%b addr=%h, required 0 1 0100",
               InstrValid, IMemReq, IMemAddr);
    end
    IMemValid    = 1'b1;
    IMemData     = 16'h1234;
    BranchTaken  = 1'b1;
    BranchTarget = 16'h0201;
    step();
    IMemValid    = 1'b0;
    BranchTaken  = 1'b0;
    checks++;
    if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 16'h0200) begin
      failures++;
      $display("FAIL branch_with_valid: valid=%b req=%b addr=%h, required 0 1 0200",
               InstrValid, IMemReq, IMemAddr);
    end
  endtask

  task automatic test_reset_midfetch();
    step();
    Reset = 1'b1;
    step();
    checks++;
    if (IMemReq !== 1'b0 || InstrValid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_ctrl: req=%b valid=%b, required 0 0", IMemReq, InstrValid);
    end
    IMemValid = 1'b1;
    IMemData  = 16'hFFFF;
    step();
    Reset = 1'b0;
    step();
    IMemValid = 1'b0;
    checks++;
    if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 16'h0000) begin
      failures++;
      $display("FAIL midreset_refetch: valid=%b req=%b addr=%h, required 0 1 0000",
               InstrValid, IMemReq, IMemAddr);
    end
    step();
    checks++;
    if (InstrValid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_late_ignored: valid=%b, required 0", InstrValid);
    end
  endtask

  task automatic test_wrap();
    w_Reset = 1'b1;
    step();
    step();
    w_Reset = 1'b0;
    step();
    checks++;
    if (w_IMemReq !== 1'b1 || w_IMemAddr !== 16'hFFFE) begin
      failures++;
      $display("FAIL wrap_first: req=%b addr=%h, required 1 FFFE", w_IMemReq, w_IMemAddr);
    end
    w_IMemValid = 1'b1;
    w_IMemData  = 16'h6C05;
    step();
    w_IMemValid = 1'b0;
    checks++;
    if (w_InstrValid !== 1'b1 || w_PCOut !== 16'hFFFE) begin
      failures++;
      $display("FAIL wrap_issue: valid=%b pc=%h, required 1 FFFE", w_InstrValid, w_PCOut);
    end
    step();
    checks++;
    if (w_IMemReq !== 1'b1 || w_IMemAddr !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_next: req=%b addr=%h, required 1 0000", w_IMemReq, w_IMemAddr);
    end
    w_Reset = 1'b1;
  endtask

  // Random stall/latency/branch traffic against a transaction-level model
  task automatic test_random(input int n);
    logic [15:0] next_pc, addr_m;
    logic        busy, br_during, exp_valid, resp, br, consume;
    int          lat;
    Reset = 1'b1;
    clear_inputs();
    step();
    step();
    Reset     = 1'b0;
    next_pc   = 16'h0000;
    addr_m    = 16'h0000;
    busy      = 1'b0;
    br_during = 1'b0;
    exp_valid = 1'b0;
    lat       = 0;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (InstrValid !== exp_valid) begin
        failures++;
        $display("FAIL rand_valid @%0d: got %b, required %b", i, InstrValid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (PCOut !== next_pc ||
            {OPCODE, Rs, Rt, Rd, Funct, Imm} !== exp_fields(memword(next_pc))) begin
          failures++;
          $display("FAIL rand_issue @%0d: pc=%h fields=%h, required %h %h", i, PCOut,
                   {OPCODE, Rs, Rt, Rd, Funct, Imm}, next_pc, exp_fields(memword(next_pc)));
        end
      end
      checks++;
      if ((IMemReq & InstrValid) !== 1'b0) begin
        failures++;
        $display("FAIL rand_one_outstanding @%0d: req=%b valid=%b, required not both",
                 i, IMemReq, InstrValid);
      end
      resp = 1'b0;
      if (IMemReq === 1'b1) begin
        if (!busy) begin
          checks++;
          if (IMemAddr !== next_pc) begin
            failures++;
            $display("FAIL rand_req_addr @%0d: got %h, required %h", i, IMemAddr, next_pc);
          end
          busy      = 1'b1;
          addr_m    = IMemAddr;
          lat       = int'($urandom_range(0, 3));
          br_during = 1'b0;
        end else begin
          checks++;
          if (IMemAddr !== addr_m) begin
            failures++;
            $display("FAIL rand_addr_stable @%0d: got %h, required %h", i, IMemAddr, addr_m);
          end
        end
        if (lat == 0) resp = 1'b1;
        else lat--;
        IMemValid = resp;
        IMemData  = resp ? memword(addr_m) : 16'($urandom);
      end else begin
        checks++;
        if (busy) begin
          failures++;
          $display("FAIL rand_req_dropped @%0d: req=%b, required 1 while outstanding", i, IMemReq);
        end
        // Spurious responses while nothing is requested must be ignored
        IMemValid = ($urandom_range(0, 3) == 0);
        IMemData  = 16'($urandom);
      end
      Stall        = ($urandom_range(0, 2) == 0);
      br           = (busy || exp_valid) && ($urandom_range(0, 7) == 0);
      BranchTaken  = br;
      BranchTarget = 16'($urandom);
      consume      = exp_valid && !Stall && !br;
      if (br) begin
        next_pc = BranchTarget & 16'hFFFE;
        if (busy) br_during = 1'b1;
      end else if (consume) begin
        next_pc = next_pc + 16'd2;
      end
      exp_valid = (resp && !br_during) || (exp_valid && Stall && !br);
      if (resp) busy = 1'b0;
      step();
    end
    clear_inputs();
    Reset = 1'b1;
    step();
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    Reset          = 1'b1;
    w_Reset        = 1'b1;
    w_IMemValid    = 1'b0;
    w_IMemData     = 16'h0000;
    w_Stall        = 1'b0;
    w_BranchTaken  = 1'b0;
    w_BranchTarget = 16'h0000;
    clear_inputs();
    test_reset();
    test_basic_issue();
    test_stall_hold();
    test_flush();
    test_branch_stall();
    test_reset_midfetch();
    test_wrap();
    test_random(4000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, byte address of the first fetch after reset.
REQ-002 Parameter: IMEM_LAT_MAX, 8, watchdog bound on request-to-valid cycles, for verification assertions only.
REQ-003 Port: Clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: Reset  input  1  synchronous, active-high reset.
REQ-005 Port: IMemReq  output  1  fetch request to instruction memory.
REQ-006 Port: IMemAddr  output  16  byte address of requested instruction word.
REQ-007 Port: IMemValid  input  1  response valid; IMemData holds the word for IMemAddr.
REQ-008 Port: IMemData  input  16  fetched instruction word.
REQ-009 Port: Stall  input  1  downstream cannot accept the issued instruction this cycle.
REQ-010 Port: BranchTaken  input  1  redirect request from execute stage.
REQ-011 Port: BranchTarget  input  16  redirect byte address; bit 0 is ignored (treated as 0).
REQ-012 Port: InstrValid  output  1  issue outputs are valid.
REQ-013 Port: OPCODE  output  3  IR[15:13], feeds the control unit directly.
REQ-014 Port: Rs, Rt, Rd  output  2 each  IR[12:11], IR[10:9], IR[8:7].
REQ-015 Port: Funct  output  3  IR[2:0].
REQ-016 Port: Imm  output  16  IR[8:0] sign-extended from bit 8.
REQ-017 Port: PCOut  output  16  byte address of the issued instruction.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH and ISSUE: IDLE->FETCH unconditionally; FETCH->ISSUE on IMemValid with no pending flush; ISSUE->FETCH when InstrValid && !Stall, or on BranchTaken.
REQ-019 In FETCH, IMemReq SHALL be 1 and IMemAddr SHALL equal PC, held stable until the cycle IMemValid is sampled high; IMemReq SHALL be 0 in IDLE and ISSUE.
REQ-020 Only one request SHALL be outstanding at a time; IMemValid outside FETCH SHALL be ignored.
REQ-021 IMemValid SHALL be accepted in the same cycle IMemReq first rises (0-wait memory) or any later cycle.
REQ-022 On an accepted response, IR<=IMemData and InstrValid SHALL be 1 from the next cycle; PCOut SHALL equal the fetch address.
REQ-023 While in ISSUE with Stall=1, IR, PCOut and all decoded outputs SHALL hold unchanged.
REQ-024 On consume (InstrValid && !Stall && !BranchTaken): PC<=PC+2, modulo 2^16 (0xFFFE wraps to 0x0000); InstrValid<=0.
REQ-025 BranchTaken SHALL have priority over consume and Stall: PC<=BranchTarget & 16'hFFFE; InstrValid<=0; next state FETCH.
REQ-026 BranchTaken in FETCH before IMemValid SHALL set a flush flag and update PC; the pending response, when it arrives, SHALL be discarded, flush cleared, and a new request issued to the new PC on the next cycle.
REQ-027 BranchTaken in the same cycle as IMemValid in FETCH SHALL discard that response and refetch from BranchTarget.
REQ-028 Steady-state throughput with 0-wait memory and Stall=0 SHALL be one instruction per 2 cycles.
REQ-029 Decoded outputs SHALL be combinational from IR only; they are don't-care when InstrValid=0 but SHALL not contain X after reset.

Reset
REQ-030 Reset SHALL set state IDLE, PC=RESET_PC, IR=16'h0000, flush=0, InstrValid=0, IMemReq=0; it overrides all other inputs, including mid-fetch (any in-flight response is then dropped).
REQ-031 The first IMemReq SHALL assert in the second cycle after Reset deasserts.

Structure
REQ-032 Opcode constants (R=3'b111, ADDI=3'b011, LW=3'b101, SW=3'b110, SLTI=3'b100), the field bit positions, and the FSM state encodings SHALL reside in a shared package cpu16_pkg.
REQ-033 Field extraction and sign extension SHALL be a sub-module instr_decode_fields; PC/IR/FSM logic stays in instruction_fetch.

Verification
REQ-034 Reset, 0-wait memory returning 16'hE283 at addr 0, Stall=0 -> IMemAddr 0x0000; OPCODE=3'b111, Rs=0, Rt=1, Rd=1, Funct=3, PCOut=0; next fetch at 0x0002.
REQ-035 Fetch 16'h61FF, Stall held 3 cycles -> InstrValid and Imm=16'hFFFF held 3 cycles; one IMemReq only; next fetch at PC+2.
REQ-036 3-cycle memory latency, BranchTaken with target 0x0041 in latency cycle 2 -> old response dropped; next IMemAddr=0x0040; no InstrValid for the dropped word.
REQ-037 BranchTaken with Stall=1 in ISSUE, target 0x0100 -> InstrValid 0 next cycle; IMemAddr=0x0100.
REQ-038 RESET_PC=0xFFFE, consume one instruction -> next IMemAddr=0x0000.
REQ-039 Reset asserted while IMemReq=1 and memory still busy -> IMemReq 0, InstrValid 0; late IMemValid ignored; refetch from RESET_PC.
